alu_sequencer: RTL

- Multi-cycle control FSM that drives the ALU's 3-bit op input and consumes its registered result flags (zero, neg).
- Accepts one instruction at a time over a valid/ready handshake and sequences the ALU, memory and register-file strobes.
- Evaluates BRZ/BRN from the ALU flags and drives PC update controls.
- Sits between the fetch stage and the datapath; it is the issuing end of the ALU op/flag interface.

---
 rtl/alu_sequencer_pkg.sv | 47 ++++
 rtl/alu_sequencer_if.sv | 40 ++++
 rtl/alu_seq_decode.sv | 45 ++++
 rtl/alu_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, ALU ops, PC select values,
// FSM states and the decoded-instruction record.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_INC  = 3'b010;
    localparam logic [2:0] ALU_NEG  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b000;
    localparam logic [2:0] ALU_PASS = 3'b111;
    localparam logic [2:0] ALU_NOP  = 3'b011;

    localparam logic [1:0] PC_NEXT = 2'd0;
    localparam logic [1:0] PC_REG  = 2'd1;
    localparam logic [1:0] PC_MEM  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       needs_mem;
        logic       mem_is_write;
        logic       reg_write;
        logic       wb_sel;
        logic       is_branch;
        logic [1:0] pc_sel;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer and its surroundings (fetch, ALU, memory, regfile, PC).
// Instruction handshake: a transfer happens on a posedge where in_instr_valid and
// out_instr_ready are both 1; the source holds in_instr stable until then.
interface alu_sequencer_if #(parameter int RW = 6);

    logic [31:0]   in_instr;
    logic          in_instr_valid;
    logic          out_instr_ready;
    logic [2:0]    out_aluop;
    logic          in_alu_zero;
    logic          in_alu_neg;
    logic [RW-1:0] out_rd;
    logic [RW-1:0] out_rs;
    logic [RW-1:0] out_rt;
    logic          out_reg_write;
    logic          out_wb_sel;
    logic          out_mem_read;
    logic          out_mem_write;
    logic          in_mem_ack;
    logic          out_pc_write;
    logic [1:0]    out_pc_sel;
    logic          out_retire;
    logic          out_illegal;
    logic          out_error;

    modport master (
        input  in_instr, in_instr_valid, in_alu_zero, in_alu_neg, in_mem_ack,
        output out_instr_ready, out_aluop, out_rd, out_rs, out_rt,
               out_reg_write, out_wb_sel, out_mem_read, out_mem_write,
               out_pc_write, out_pc_sel, out_retire, out_illegal, out_error
    );

    modport slave (
        output in_instr, in_instr_valid, in_alu_zero, in_alu_neg, in_mem_ack,
        input  out_instr_ready, out_aluop, out_rd, out_rs, out_rt,
               out_reg_write, out_wb_sel, out_mem_read, out_mem_write,
               out_pc_write, out_pc_sel, out_retire, out_illegal, out_error
    );

endinterface

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode to the control record the
// sequencer FSM uses in EXEC, MEM and WB.
module alu_seq_decode
    import alu_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.aluop  = ALU_NOP;
        dec.pc_sel = PC_NEXT;
        dec.legal  = 1'b1;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin dec.aluop = ALU_ADD; dec.reg_write = 1'b1; end
            OP_INC: begin dec.aluop = ALU_INC; dec.reg_write = 1'b1; end
            OP_NEG: begin dec.aluop = ALU_NEG; dec.reg_write = 1'b1; end
            OP_SUB: begin dec.aluop = ALU_SUB; dec.reg_write = 1'b1; end
            // SVPC computes its value through the adder
            OP_SVPC: begin dec.aluop = ALU_ADD; dec.reg_write = 1'b1; end
            OP_LD: begin
                dec.needs_mem = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = 1'b1;
            end
            OP_ST: begin
                dec.needs_mem    = 1'b1;
                dec.mem_is_write = 1'b1;
            end
            OP_J:   dec.pc_sel = PC_REG;
            OP_BRZ, OP_BRN: begin
                dec.is_branch = 1'b1;
                dec.pc_sel    = PC_REG;
            end
            OP_JM: begin
                dec.needs_mem = 1'b1;
                dec.pc_sel    = PC_MEM;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM (IDLE/EXEC/MEM/WB) that issues ALU ops, memory requests,
// register writes and PC updates for one instruction at a time.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RW          = 6
)(
    input  logic              clk,
    input  logic              in_rst_n,
    alu_sequencer_if.master   bus,
    output state_t            dbg_state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        state, state_nx;
    logic [3:0]    opcode_q;
    logic [RW-1:0] rd_q, rs_q, rt_q;
    logic [1:0]    pc_sel_q;
    logic [CW-1:0] tmo_cnt;
    logic          error_q;

    logic [3:0]    dec_opcode;
    dec_t          dec;
    logic          accept, mem_ack, timeout_hit, branch_taken;
    logic          unused_instr_bits;

    // Decode the incoming word while idle, the latched opcode afterwards
    assign dec_opcode = (state == S_IDLE) ? bus.in_instr[31:28] : opcode_q;

    alu_seq_decode u_decode (
        .opcode (dec_opcode),
        .dec    (dec)
    );

    assign accept       = (state == S_IDLE) && bus.in_instr_valid;
    assign mem_ack      = (state == S_MEM) && bus.in_mem_ack;
    // An ack in the final allowed cycle takes priority over the timeout
    assign timeout_hit  = (state == S_MEM) && !bus.in_mem_ack &&
                          (tmo_cnt == CW'(MEM_TIMEOUT - 1));
    assign branch_taken = (opcode_q == OP_BRZ) ? bus.in_alu_zero : bus.in_alu_neg;

    assign unused_instr_bits = ^bus.in_instr[9:0];
    assign dbg_state         = state;
    assign bus.out_rd        = rd_q;
    assign bus.out_rs        = rs_q;
    assign bus.out_rt        = rt_q;
    assign bus.out_error     = error_q;

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept && dec.legal && (dec_opcode != OP_NOP)) state_nx = S_EXEC;
            S_EXEC: state_nx = dec.needs_mem ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ack)          state_nx = S_WB;
                else if (timeout_hit) state_nx = S_IDLE;
            end
            S_WB:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.out_instr_ready = 1'b0;
        bus.out_aluop       = ALU_NOP;
        bus.out_reg_write   = 1'b0;
        bus.out_wb_sel      = 1'b0;
        bus.out_mem_read    = 1'b0;
        bus.out_mem_write   = 1'b0;
        bus.out_pc_write    = 1'b0;
        bus.out_pc_sel      = PC_NEXT;
        bus.out_retire      = 1'b0;
        bus.out_illegal     = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.out_instr_ready = 1'b1;
                if (accept && !dec.legal) begin
                    bus.out_illegal = 1'b1;
                    bus.out_retire  = 1'b1;
                end
                if (accept && (dec_opcode == OP_NOP)) bus.out_retire = 1'b1;
            end
            S_EXEC: bus.out_aluop = dec.aluop;
            S_MEM: begin
                bus.out_mem_read  = !dec.mem_is_write;
                bus.out_mem_write = dec.mem_is_write;
                bus.out_retire    = timeout_hit;
            end
            S_WB: begin
                bus.out_reg_write = dec.reg_write;
                bus.out_wb_sel    = dec.wb_sel;
                bus.out_pc_write  = 1'b1;
                bus.out_pc_sel    = pc_sel_q;
                bus.out_retire    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            opcode_q <= OP_NOP;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            pc_sel_q <= PC_NEXT;
            tmo_cnt  <= '0;
            error_q  <= 1'b0;
        end else begin
            if (accept) begin
                opcode_q <= bus.in_instr[31:28];
                rd_q     <= bus.in_instr[27 -: RW];
                rs_q     <= bus.in_instr[21 -: RW];
                rt_q     <= bus.in_instr[15 -: RW];
            end
            if (state == S_EXEC) begin
                pc_sel_q <= dec.is_branch ? (branch_taken ? PC_REG : PC_NEXT) : dec.pc_sel;
                tmo_cnt  <= '0;
            end
            if (state == S_MEM) tmo_cnt <= tmo_cnt + 1'b1;
            if (timeout_hit)    error_q <= 1'b1;
        end
    end

endmodule
